// File: rtl/conv_logic_unit_if.sv
// Handshake bus of conv_logic_unit: operand beat channel in, result channel out.
// The slave modport is the unit's view; the master modport is the
// upstream/downstream environment's view.
interface conv_logic_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;
  logic [2:0]                  in_op;
  logic [1:0]                  in_red;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic                        out_last;
  logic [CNT_WIDTH-1:0]        out_beats;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_red, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_beats
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_red, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_beats
  );
endinterface

// File: rtl/conv_logic_unit.sv
// Multi-lane bitwise logic unit: one of eight bitwise ops per operand pair,
// emitted per beat or AND/OR/XOR-reduced across a burst, with one registered
// output stage behind a valid/ready handshake.
module conv_logic_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_logic_unit_if.slave     bus
);
  localparam int W = LANES * DATA_WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Bitwise ops act bit-by-bit, so lanes are independent with no cross-lane carry.
  function automatic logic [W-1:0] logic_op(input logic [2:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a & ~b;
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Combine the running accumulator with the current beat result.
  function automatic logic [W-1:0] reduce_op(input logic [1:0] red,
                                             input logic [W-1:0] acc,
                                             input logic [W-1:0] r);
    logic [W-1:0] y;
    case (red)
      2'b01:   y = acc & r;
      2'b10:   y = acc | r;
      2'b11:   y = acc ^ r;
      default: y = r;
    endcase
    return y;
  endfunction

  state_e               state_q;
  logic [2:0]           cfg_op_q;
  logic [1:0]           cfg_red_q;
  logic [W-1:0]         acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 out_valid_q;
  logic [W-1:0]         out_data_q;
  logic                 out_last_q;
  logic [CNT_WIDTH-1:0] out_beats_q;

  logic                 accept_s;
  logic                 first_s;
  logic [2:0]           op_s;
  logic [1:0]           red_s;
  logic [W-1:0]         beat_r_s;
  logic [W-1:0]         acc_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 produce_s;
  logic [W-1:0]         result_s;

  // Ready depends only on the output stage, never on in_valid.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_beats = out_beats_q;

  // Beat datapath: effective config, beat result, next accumulator and count.
  always_comb begin
    accept_s = bus.in_valid && bus.in_ready;
    first_s  = (state_q == ST_IDLE);
    if (first_s) begin
      op_s  = bus.in_op;
      red_s = bus.in_red;
    end else begin
      op_s  = cfg_op_q;
      red_s = cfg_red_q;
    end
    beat_r_s = logic_op(op_s, bus.in_a, bus.in_b);
    if (first_s) begin
      acc_d = beat_r_s;
      cnt_d = CNT_WIDTH'(1);
    end else begin
      acc_d = reduce_op(red_s, acc_q, beat_r_s);
      if (cnt_q == {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
    if (red_s == 2'b00) begin
      result_s = beat_r_s;
    end else begin
      result_s = acc_d;
    end
    produce_s = accept_s && ((red_s == 2'b00) || bus.in_last);
  end

  // Burst FSM, accumulator, beat counter and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_op_q    <= 3'b000;
      cfg_red_q   <= 2'b00;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      if (accept_s) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.in_last) begin
              acc_q <= '0;
              cnt_q <= '0;
            end else begin
              cfg_op_q  <= bus.in_op;
              cfg_red_q <= bus.in_red;
              acc_q     <= acc_d;
              cnt_q     <= cnt_d;
              state_q   <= ST_BURST;
            end
          end
          ST_BURST: begin
            if (bus.in_last) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end
          end
          default: begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end

      if (produce_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result_s;
        out_last_q  <= bus.in_last;
        out_beats_q <= cnt_d;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_logic_unit.sv
// Directed self-checking bench for conv_logic_unit.
module tb_conv_logic_unit;
  localparam int DW = 8;
  localparam int LN = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  conv_logic_unit_if #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) bus ();

  conv_logic_unit #(.DATA_WIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for acceptance, then drop in_valid.
  task automatic beat(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [1:0] red, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_red   = red;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("beat_accept_timeout", 64'd0, 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] op_exp [8];
  logic [31:0] held;
  int          early_out;

  initial begin
    n_vec = 0;
    n_err = 0;
    op_exp[0] = 32'hF000_0A05;
    op_exp[1] = 32'hFFF0_AF5F;
    op_exp[2] = 32'h0FF0_A55A;
    op_exp[3] = 32'h0FFF_F5FA;
    op_exp[4] = 32'h000F_50A0;
    op_exp[5] = 32'hF00F_5AA5;
    op_exp[6] = 32'h00F0_A050;
    op_exp[7] = 32'hF0F0_AA55;

    // Reset held two cycles with a valid beat presented.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'hFFFF_FFFF;
    bus.in_b      = 32'hFFFF_FFFF;
    bus.in_op     = 3'b000;
    bus.in_red    = 2'b00;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, bus.out_data}, 64'd0);
    chk("rst_out_last",  {63'd0, bus.out_last}, 64'd0);
    chk("rst_out_beats", {56'd0, bus.out_beats}, 64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    step();
    chk("post_rst_idle", {63'd0, bus.out_valid}, 64'd0);

    // Per-beat op sweep, single-beat bursts.
    for (int i = 0; i < 8; i++) begin
      beat(32'hF0F0_AA55, 32'hFF00_0F0F, 3'(i), 2'b00, 1'b1);
      chk($sformatf("op%0d_data", i), {32'd0, bus.out_data}, {32'd0, op_exp[i]});
      chk($sformatf("op%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("op%0d_last", i), {63'd0, bus.out_last}, 64'd1);
      chk($sformatf("op%0d_beats", i), {56'd0, bus.out_beats}, 64'd1);
    end
    step();
    chk("sweep_drained", {63'd0, bus.out_valid}, 64'd0);

    // Per-beat burst of two: second beat's op is ignored (XOR latched).
    beat(32'hF0F0_AA55, 32'hFF00_0F0F, 3'b010, 2'b00, 1'b0);
    chk("pb1_data",  {32'd0, bus.out_data}, 64'h0FF0_A55A);
    chk("pb1_last",  {63'd0, bus.out_last}, 64'd0);
    chk("pb1_beats", {56'd0, bus.out_beats}, 64'd1);
    beat(32'hF0F0_AA55, 32'hFF00_0F0F, 3'b000, 2'b00, 1'b1);
    chk("pb2_data",  {32'd0, bus.out_data}, 64'h0FF0_A55A);
    chk("pb2_last",  {63'd0, bus.out_last}, 64'd1);
    chk("pb2_beats", {56'd0, bus.out_beats}, 64'd2);
    step();

    // AND-reduce, op OR: 0xFF & 0x03 & 0xFF = 0x03; later op/red changes ignored.
    beat(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b001, 2'b01, 1'b0);
    chk("red_b1_noout", {63'd0, bus.out_valid}, 64'd0);
    beat(32'h0101_0101, 32'h0202_0202, 3'b000, 2'b00, 1'b0);
    chk("red_b2_noout", {63'd0, bus.out_valid}, 64'd0);
    beat(32'hFFFF_FFFF, 32'h0000_0000, 3'b000, 2'b00, 1'b1);
    chk("red_data",  {32'd0, bus.out_data}, 64'h0303_0303);
    chk("red_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("red_last",  {63'd0, bus.out_last}, 64'd1);
    chk("red_beats", {56'd0, bus.out_beats}, 64'd3);
    step();

    // Backpressure: result A held while stalled, B loads as A drains.
    beat(32'h1234_5678, 32'hFFFF_0000, 3'b000, 2'b00, 1'b1);
    held = bus.out_data;
    chk("bp_a_data", {32'd0, held}, 64'h1234_0000);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'hAAAA_AAAA;
    bus.in_b      = 32'h5555_5555;
    bus.in_op     = 3'b001;
    bus.in_red    = 2'b00;
    bus.in_last   = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_stall%0d_ready", i), {63'd0, bus.in_ready}, 64'd0);
      chk($sformatf("bp_stall%0d_data", i), {32'd0, bus.out_data}, 64'h1234_0000);
      step();
    end
    chk("bp_stall_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_b_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_b_data",  {32'd0, bus.out_data}, 64'hFFFF_FFFF);
    step();
    chk("bp_no_dup", {63'd0, bus.out_valid}, 64'd0);

    // Saturation: XOR-reduce PASS of indices 1..300 (mod 256) gives 0x2C per lane.
    early_out = 0;
    for (int i = 1; i <= 300; i++) begin
      beat({4{8'(i)}}, 32'h0000_0000, 3'b111, 2'b11, (i == 300) ? 1'b1 : 1'b0);
      if (i < 300 && bus.out_valid) early_out++;
    end
    chk("sat_no_early", 64'(early_out), 64'd0);
    chk("sat_data",  {32'd0, bus.out_data}, 64'h2C2C_2C2C);
    chk("sat_beats", {56'd0, bus.out_beats}, 64'd255);
    chk("sat_last",  {63'd0, bus.out_last}, 64'd1);
    step();

    // Reset mid-burst: partial OR-reduce discarded, next single beat starts fresh.
    beat(32'h0F0F_0F0F, 32'h0000_0000, 3'b001, 2'b10, 1'b0);
    beat(32'hF0F0_F0F0, 32'h0000_0000, 3'b001, 2'b10, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    rst_n = 1'b1;
    beat(32'hF0F0_AA55, 32'hFF00_0F0F, 3'b000, 2'b00, 1'b1);
    chk("mid_rst_data",  {32'd0, bus.out_data}, 64'hF000_0A05);
    chk("mid_rst_beats", {56'd0, bus.out_beats}, 64'd1);
    chk("mid_rst_last",  {63'd0, bus.out_last}, 64'd1);
    step();
    chk("mid_rst_drain", {63'd0, bus.out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
